// File: rtl/framebuffer_writer.sv
// Pixel-write initiator: culls off-screen pixels, buffers them in a FIFO and streams them
// to the framebuffer over valid/ready. Optional macro FRAMEBUFFER_WRITER_PIXEL_COUNT_EN adds a per-frame pixel counter.
module framebuffer_writer #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic [8:0]  x_in,
    input  logic [7:0]  y_in,
    input  logic [15:0] z_in,
    input  logic [11:0] rgb_in,
    input  logic        flush_in,
    output logic        done_out,
    output logic        valid_out,
    input  logic        ready_in,
    output logic [8:0]  x_out,
    output logic [7:0]  y_out,
    output logic [15:0] z_out,
    output logic [11:0] rgb_out,
    output logic        overflow_out,
    output logic [15:0] pixel_count_out
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    logic [44:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [AW:0]   w_count_next;
    state_t        r_state;
    state_t        w_state_next;
    logic          r_ready;
    logic          r_valid;
    logic          r_done;
    logic          r_overflow;
    logic [44:0]   r_data;
    logic          w_in_range;
    logic          w_push;
    logic          w_pop;

    assign w_in_range = (32'(x_in) < 32'(WIDTH)) && (32'(y_in) < 32'(HEIGHT));
    assign w_push     = valid_in && r_ready && w_in_range;
    assign w_pop      = (r_count != CNT_ZERO) && (!r_valid || ready_in);

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CNT_ONE;
        end else begin
            w_count_next = r_count;
        end
    end

    // Frame FSM next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (flush_in) begin
                    w_state_next = ST_DRAIN;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if ((r_count == CNT_ZERO) && !r_valid) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DONE:  w_state_next = ST_RUN;
            default:  w_state_next = ST_RUN;
        endcase
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {x_in, y_in, z_in, rgb_in};
        end
    end

    // Pointers, count, state, output register and status flags
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wr_ptr   <= {AW{1'b0}};
            r_rd_ptr   <= {AW{1'b0}};
            r_count    <= CNT_ZERO;
            r_state    <= ST_RUN;
            r_ready    <= 1'b1;
            r_valid    <= 1'b0;
            r_data     <= 45'd0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_valid  <= 1'b1;
                r_data   <= r_mem[r_rd_ptr];
            end else if (ready_in) begin
                r_valid  <= 1'b0;
            end
            r_count <= w_count_next;
            r_state <= w_state_next;
            // ready reflects the occupancy and state the next cycle will actually see
            r_ready <= (w_count_next < CNT_FULL) && (w_state_next == ST_RUN);
            r_done  <= (w_state_next == ST_DONE);
            if (valid_in && !r_ready && w_in_range) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef FRAMEBUFFER_WRITER_PIXEL_COUNT_EN
    logic        w_xfer;
    logic [15:0] r_pix_cnt;
    logic [15:0] r_pix_cnt_out;

    assign w_xfer = r_valid && ready_in;

    // Per-frame transfer counter, published on entry to Done
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_pix_cnt     <= 16'd0;
            r_pix_cnt_out <= 16'd0;
        end else begin
            if (r_state == ST_DONE) begin
                r_pix_cnt <= w_xfer ? 16'd1 : 16'd0;
            end else if (w_xfer && (r_pix_cnt != 16'hFFFF)) begin
                r_pix_cnt <= r_pix_cnt + 16'd1;
            end
            if (w_state_next == ST_DONE) begin
                r_pix_cnt_out <= r_pix_cnt;
            end
        end
    end

    assign pixel_count_out = r_pix_cnt_out;
`else
    assign pixel_count_out = 16'd0;
`endif

    assign ready_out    = r_ready;
    assign valid_out    = r_valid;
    assign done_out     = r_done;
    assign overflow_out = r_overflow;
    assign x_out        = r_data[44:36];
    assign y_out        = r_data[35:28];
    assign z_out        = r_data[27:12];
    assign rgb_out      = r_data[11:0];
endmodule
